// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-side branch prediction controller.
package bp_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  localparam int unsigned PRED_TGT_W = 32;

  typedef struct packed {
    logic                  taken;
    logic [PRED_TGT_W-1:0] target;
  } pred_t;

  localparam logic [1:0] CNT_RESET = 2'b01;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating direction counters: async fetch read, sync EX update.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0] cnt_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_RESET;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_taken_i ? sat_inc(cnt_q[upd_idx_i])
                                      : sat_dec(cnt_q[upd_idx_i]);
    end
  end

  // No bypass: a same-cycle update of the read entry is seen next cycle.
  assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch PC selection from BTB + direction counters, EX-stage resolve and
// single-cycle mispredict recovery (flush, redirect, BTB write).
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned MISS_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [DATA_W-1:0] pc_if,
  input  logic              btb_hit,
  input  logic [DATA_W-1:0] btb_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_target,
  output logic              pred_taken,
  output logic [DATA_W-1:0] next_pc,
  output logic              flush,
  output logic              btb_wr_en,
  output logic [DATA_W-1:0] btb_wr_pc,
  output logic [DATA_W-1:0] btb_wr_target,
  output logic [MISS_W-1:0] mispred_cnt
);

  // Same layout as pred_t, but with the target following DATA_W.
  typedef struct packed {
    logic              taken;
    logic [DATA_W-1:0] target;
  } stage_t;

  state_t              state_q;
  stage_t              p_id_q, p_ex_q;
  logic                lat_taken_q;
  logic [DATA_W-1:0]   lat_pc_q, lat_tgt_q;
  logic [MISS_W-1:0]   miss_q;
  logic [1:0]          fetch_cnt;
  logic                in_recover;
  logic                resolve;
  logic                mispredict;

  bp_counter_table #(
    .IDX_W (IDX_W)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (pc_if[IDX_W+1:2]),
    .rd_cnt_o    (fetch_cnt),
    .upd_en_i    (resolve),
    .upd_idx_i   (ex_pc[IDX_W+1:2]),
    .upd_taken_i (ex_taken)
  );

  assign in_recover = (state_q == RECOVER);
  assign pred_taken = btb_hit & fetch_cnt[1];

  // EX inputs are wrong-path while recovering, so resolve only in RUN.
  assign resolve    = !in_recover & ex_valid & ex_is_branch;
  assign mispredict = resolve &
                      ((ex_taken != p_ex_q.taken) |
                       (ex_taken & (ex_target != p_ex_q.target)));

  always_comb begin
    next_pc = pc_if + DATA_W'(4);
    if (in_recover) begin
      next_pc = lat_taken_q ? lat_tgt_q : lat_pc_q + DATA_W'(4);
    end else if (pred_taken) begin
      next_pc = btb_target;
    end
  end

  assign flush         = in_recover;
  assign btb_wr_en     = in_recover & lat_taken_q;
  assign btb_wr_pc     = lat_pc_q;
  assign btb_wr_target = lat_tgt_q;
  assign mispred_cnt   = miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_id_q <= '0;
      p_ex_q <= '0;
    end else if (flush) begin
      p_id_q <= '0;
      p_ex_q <= '0;
    end else if (!stall) begin
      p_id_q.taken  <= pred_taken;
      p_id_q.target <= btb_target;
      p_ex_q        <= p_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      lat_taken_q <= 1'b0;
      lat_pc_q    <= '0;
      lat_tgt_q   <= '0;
      miss_q      <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mispredict) begin
            state_q     <= RECOVER;
            lat_taken_q <= ex_taken;
            lat_pc_q    <= ex_pc;
            lat_tgt_q   <= ex_target;
            if (miss_q != '1) begin
              miss_q <= miss_q + MISS_W'(1);
            end
          end
        end
        RECOVER: state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Fetch-side branch prediction controller that sequences the `Branch_Target` BTB.
- Combines BTB `Hit`/`Target_Add` with a table of 2-bit saturating direction counters to choose the next fetch PC.
- Carries each prediction down the pipeline to EX and compares it with the resolved branch.
- On a mispredict, runs a one-cycle recovery that flushes IF/ID/EX, redirects fetch and schedules the BTB write.
- Sits between the PC register, the BTB and the EX-stage branch unit.

## Interface
- `DATA_W`, 32, PC/target width
- `IDX_W`, 3, counter-table index bits (depth `1<<IDX_W`, index = `pc[IDX_W+1:2]`)
- `MISS_W`, 16, mispredict counter width
- `clk` in 1: rising-edge clock
- `rst_n` in 1: one clock; reset is asynchronous and active-low
- `stall` in 1: hold prediction pipeline
- `pc_if` in DATA_W: current fetch PC
- `btb_hit` in 1: BTB `Hit` for `pc_if`
- `btb_target` in DATA_W: BTB `Target_Add`
- `ex_valid` in 1: EX stage holds a valid instruction
- `ex_is_branch` in 1: EX instruction is a branch/jump
- `ex_taken` in 1: resolved direction
- `ex_pc` in DATA_W: EX instruction PC
- `ex_target` in DATA_W: resolved target (ALU result)
- `pred_taken` out 1: fetch prediction for `pc_if`
- `next_pc` out DATA_W: next fetch PC
- `flush` out 1: kill IF/ID/EX contents
- `btb_wr_en` out 1: BTB update strobe (`Br_Detected`)
- `btb_wr_pc` out DATA_W: BTB update PC (`PC_Ex`)
- `btb_wr_target` out DATA_W: BTB update target (`PC_ALU`)
- `mispred_cnt` out MISS_W: saturating mispredict count

## Operation
- **Counter table:** `1<<IDX_W` 2-bit entries, reset to 01 (weak not-taken). Bit 1 is the taken prediction.
- **Predict (combinational):**
  - `pred_taken = btb_hit & cnt[idx(pc_if)][1]`.
  - In RUN: `next_pc = pred_taken ? btb_target : pc_if + 4`, truncated modulo 2^DATA_W.
- **Prediction pipeline:** two register stages (IF→ID, ID→EX), each holding `{taken, target}`.
  - Advance when `!stall`.
  - Load zero when `flush`.
- **Resolve:** when `ex_valid & ex_is_branch` in RUN, mispredict is either of:
  - `ex_taken != p_ex.taken`
  - `ex_taken & (ex_target != p_ex.target)`
- **Counter update:** at that same edge, update `cnt[idx(ex_pc)]`, whether or not the branch mispredicted.
  - Taken: saturating increment.
  - Not taken: saturating decrement.
  - Holds at 00 and 11.
- **FSM states:** RUN and RECOVER.
  - **RUN → RECOVER:** on mispredict. Latch `ex_pc`, `ex_target`, `ex_taken`.
  - **RECOVER (exactly 1 cycle, then → RUN):**
    - `flush = 1`.
    - `next_pc = lat_taken ? lat_target : lat_pc + 4`.
    - `btb_wr_en = lat_taken`, with `btb_wr_pc = lat_pc` and `btb_wr_target = lat_target`.
    - `mispred_cnt` increments (saturates at all-ones).
    - Not-taken mispredicts write nothing to the BTB.
- **Priority and corner cases:**
  - Flush/RECOVER has priority over `stall`: RECOVER never extends.
  - EX inputs are ignored in RECOVER (wrong path).
  - Same-cycle fetch read and EX update of one counter entry: fetch sees the old value (no bypass).
  - Correctly predicted branches: counter update only, no flush, no BTB write.

## Timing
- Prediction: 0-cycle combinational from `pc_if`/`btb_*`.
- Mispredict at EX in cycle N → `flush`, redirect and `btb_wr_en` valid for cycle N+1 only.
  - The BTB captures the write on the edge ending N+1.
  - Counter updated on the edge ending N.
- Minimum spacing between two recoveries: 2 cycles.
- **Reset values:**
  - FSM = RUN; pipeline regs 0; latches 0; counters 01.
  - `flush`, `btb_wr_en`, `mispred_cnt`, `btb_wr_pc`, `btb_wr_target` = 0.
  - `pred_taken` = 0, so `next_pc = pc_if + 4`.
- **Reset mid-RECOVER:** `flush` and `btb_wr_en` drop immediately (asynchronously); no BTB write occurs.

## Structure
- **`bp_pkg`:**
  - `state_t` enum {RUN, RECOVER}.
  - `pred_t` struct {taken, target}.
  - `CNT_RESET = 2'b01`.
  - `sat_inc`/`sat_dec` functions.
- **Sub-module `bp_counter_table`:**
  - One async read port (fetch index).
  - One sync update port (index, taken, enable).
  - Async reset of all entries.
- **Top level:** prediction pipeline, resolve compare, FSM, latches, miss counter.

## Test plan
- Reset with `pc_if = 0x1234_0000`, `btb_hit = 1` → `pred_taken = 0`, `next_pc = 0x1234_0004`, `flush = 0`, `btb_wr_en = 0`, `mispred_cnt = 0`.
- Cold branch resolves at `ex_pc = 0x1234_0000`, taken to `0xFFFF_AAAA`, predicted not-taken:
  - Next cycle: `flush = 1`, `next_pc = 0xFFFF_AAAA`, `btb_wr_en = 1`, `btb_wr_pc = 0x1234_0000`, `btb_wr_target = 0xFFFF_AAAA`.
  - `cnt[0]` goes 01→10; `mispred_cnt = 1`; one cycle later `flush = 0`.
- Refetch `0x1234_0000` with `btb_hit = 1`, `btb_target = 0xFFFF_AAAA`:
  - `pred_taken = 1`, `next_pc = 0xFFFF_AAAA`.
  - Resolves taken to the same target → no flush, no BTB write, `cnt[0] = 11`.
- Predicted taken to `0xFFFF_AAAA`, resolves taken to `0xAAAA_AAAA` → `flush = 1`, `next_pc = 0xAAAA_AAAA`, BTB rewritten with `0xAAAA_AAAA`.
- Predicted taken, resolves not-taken at `0x1234_0000` → `flush = 1`, `next_pc = 0x1234_0004`, `btb_wr_en = 0`, counter decremented by one.
- Two variants:
  - `stall = 1` held across a mispredict → RECOVER still lasts exactly 1 cycle.
  - `rst_n` pulled low during RECOVER → `flush = 0` and `btb_wr_en = 0` immediately; counters back to 01.
